// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: key synchronise/debounce, 10 ms prescaler and centisecond count.
// Exports a live count and a freezable display copy for the downstream decoders.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_reset_n,
  input  logic        key_start_n,
  input  logic        key_disp_n,
  output logic [18:0] live_count,
  output logic [18:0] disp_count,
  output logic        running,
  output logic        frozen,
  output logic        tick
);

  localparam int unsigned CW = 19;
  localparam int unsigned NK = 3;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(359999);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned K_RESET = 0;
  localparam int unsigned K_START = 1;
  localparam int unsigned K_DISP  = 2;

  logic [NK-1:0] keys;
  logic [NK-1:0] sync1;
  logic [NK-1:0] sync2;
  logic [NK-1:0] level;
  logic [NK-1:0] level_d;
  logic [NK-1:0] press;
  logic [DW-1:0] db_cnt [NK];
  logic [PW-1:0] presc;

  assign keys = {key_disp_n, key_start_n, key_reset_n};

  // Two-flop synchronisers; idle (released) level is 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Per-key debouncer: a level change needs DEBOUNCE_CYCLES consecutive differing samples.
  for (genvar k = 0; k < NK; k++) begin : g_db
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        level[k]  <= 1'b1;
        db_cnt[k] <= '0;
      end else if (sync2[k] == level[k]) begin
        db_cnt[k] <= '0;
      end else if (db_cnt[k] == DB_MAX) begin
        level[k]  <= sync2[k];
        db_cnt[k] <= '0;
      end else begin
        db_cnt[k] <= db_cnt[k] + DW'(1);
      end
    end
  end

  // Press pulse on the debounced falling edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= '1;
      press   <= '0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

  // Run/freeze flags, prescaler, centisecond count and display copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running    <= 1'b0;
      frozen     <= 1'b0;
      tick       <= 1'b0;
      presc      <= '0;
      live_count <= '0;
      disp_count <= '0;
    end else if (press[K_RESET]) begin
      // Reset press wins: coincident start/display presses and ticks are dropped.
      running    <= 1'b0;
      frozen     <= 1'b0;
      tick       <= 1'b0;
      presc      <= '0;
      live_count <= '0;
      disp_count <= '0;
    end else begin
      tick <= 1'b0;
      if (press[K_START]) running <= ~running;
      if (press[K_DISP])  frozen  <= ~frozen;
      if (running) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (tick) live_count <= (live_count == COUNT_MAX) ? '0 : live_count + CW'(1);
      if (!frozen) disp_count <= live_count;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: instance a (TICK_DIV=4) for key/prescale/freeze
// behaviour, instance b (TICK_DIV=1) for per-cycle ticking and the 359999 wrap.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kr_a, ks_a, kd_a, kr_b, ks_b, kd_b;
  logic [18:0] live_a, disp_a, live_b, disp_b;
  logic        running_a, frozen_a, tick_a, running_b, frozen_b, tick_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .key_reset_n(kr_a), .key_start_n(ks_a), .key_disp_n(kd_a),
    .live_count(live_a), .disp_count(disp_a),
    .running(running_a), .frozen(frozen_a), .tick(tick_a)
  );

  stopwatch_ctrl #(.TICK_DIV(1), .DEBOUNCE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .key_reset_n(kr_b), .key_start_n(ks_b), .key_disp_n(kd_b),
    .live_count(live_b), .disp_count(disp_b),
    .running(running_b), .frozen(frozen_b), .tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edge numbers in comments: Pn is the n-th posedge after the first low sample of the
  // long start press on instance a.
  initial begin
    rst_n = 1'b0;
    kr_a = 1'b1; ks_a = 1'b1; kd_a = 1'b1;
    kr_b = 1'b1; ks_b = 1'b1; kd_b = 1'b1;
    step(2);
    chk("rst_live",    32'(live_a),    0);
    chk("rst_disp",    32'(disp_a),    0);
    chk("rst_running", 32'(running_a), 0);
    chk("rst_frozen",  32'(frozen_a),  0);
    chk("rst_tick",    32'(tick_a),    0);
    chk("rst_b_live",  32'(live_b),    0);
    rst_n = 1'b1;
    step(100);
    chk("idle_running", 32'(running_a), 0);
    chk("idle_live",    32'(live_a),    0);

    // Two low cycles then single-cycle glitches: never stable for 3 cycles.
    ks_a = 1'b0;
    step(2);
    for (int i = 0; i < 8; i++) begin
      ks_a = ~ks_a;
      step(1);
    end
    ks_a = 1'b1;
    step(10);
    chk("glitch_running", 32'(running_a), 0);

    // Held press: running rises at P6 (2 sync + 3 debounce + 1 pulse).
    ks_a = 1'b0;
    step(6);
    chk("press_p5_running", 32'(running_a), 0);
    step(1);
    chk("press_p6_running", 32'(running_a), 1);
    step(3);
    ks_a = 1'b1;                 // after P9
    step(4);
    chk("release_running", 32'(running_a), 1);

    // Pause: ticks at P10/P14/P18 -> live 3; running clears at P20 with prescaler at 2.
    ks_a = 1'b0;                 // first sample P14
    step(6);
    ks_a = 1'b1;
    step(1);                     // P20
    chk("pause_running", 32'(running_a), 0);
    chk("pause_live",    32'(live_a),    3);
    step(20);                    // P40
    chk("paused_live", 32'(live_a), 3);
    chk("paused_tick", 32'(tick_a), 0);

    // Resume: running at P47, prescaler 2->3 at P48, wraps with tick at P49.
    ks_a = 1'b0;
    step(6);
    ks_a = 1'b1;
    step(1);                     // P47
    chk("resume_running", 32'(running_a), 1);
    chk("resume_tick47",  32'(tick_a),    0);
    step(1);                     // P48
    chk("resume_tick48",  32'(tick_a),    0);
    step(1);                     // P49
    chk("resume_tick49",  32'(tick_a),    1);
    chk("resume_live49",  32'(live_a),    3);
    step(1);                     // P50
    chk("resume_live50",  32'(live_a),    4);

    // Freeze: live = 4+j over P50+4j..P53+4j; frozen sets at P76 holding 10.
    step(19);                    // P69
    kd_a = 1'b0;
    step(6);
    kd_a = 1'b1;
    step(1);                     // P76
    chk("freeze_frozen", 32'(frozen_a), 1);
    chk("freeze_disp",   32'(disp_a),   10);
    chk("freeze_live",   32'(live_a),   10);
    step(38);                    // P114
    chk("frozen_live20", 32'(live_a), 20);
    chk("frozen_disp10", 32'(disp_a), 10);
    kd_a = 1'b0;
    step(6);
    kd_a = 1'b1;
    step(1);                     // P121
    chk("unfreeze_frozen", 32'(frozen_a), 0);
    chk("unfreeze_hold",   32'(disp_a),   10);
    step(1);                     // P122
    chk("unfreeze_disp122", 32'(disp_a), 21);
    chk("unfreeze_live122", 32'(live_a), 22);
    step(1);                     // P123
    chk("unfreeze_disp123", 32'(disp_a), 22);

    // Reset and start presses debounced together at live = 57 (P262..P265).
    step(134);                   // P257
    kr_a = 1'b0;
    ks_a = 1'b0;
    step(6);                     // P263
    chk("simul_pre_live",    32'(live_a),    57);
    chk("simul_pre_running", 32'(running_a), 1);
    kr_a = 1'b1;
    ks_a = 1'b1;
    step(1);                     // P264
    chk("simul_live",    32'(live_a),    0);
    chk("simul_running", 32'(running_a), 0);
    chk("simul_frozen",  32'(frozen_a),  0);
    step(1);                     // P265
    chk("simul_disp",      32'(disp_a), 0);
    chk("simul_live_hold", 32'(live_a), 0);

    // rst_n mid-debounce: only 2 post-reset low samples, so no press survives.
    step(5);                     // P270
    ks_a = 1'b0;                 // first sample P271
    step(3);
    rst_n = 1'b0;                // reset edge P274
    step(1);
    rst_n = 1'b1;
    step(2);                     // P276
    ks_a = 1'b1;
    step(12);
    chk("midrst_running", 32'(running_a), 0);
    chk("midrst_live",    32'(live_a),    0);

    // Key held low through rst_n release: full debounce counted from the release.
    ks_a = 1'b0;                 // first sample P289
    step(2);
    rst_n = 1'b0;                // reset edge P291
    step(1);
    rst_n = 1'b1;
    step(6);                     // P297
    chk("held_rst_p297", 32'(running_a), 0);
    step(1);                     // P298
    chk("held_rst_p298", 32'(running_a), 1);
    ks_a = 1'b1;

    // Instance b: tick every running cycle, then wrap from 359999 to 0.
    step(5);                     // P303
    ks_b = 1'b0;
    step(6);
    ks_b = 1'b1;
    step(1);                     // P310
    chk("b_running", 32'(running_b), 1);
    step(1);                     // P311
    chk("b_tick311", 32'(tick_b), 1);
    chk("b_live311", 32'(live_b), 0);
    step(3);                     // P314
    chk("b_live314", 32'(live_b), 3);
    force dut_b.live_count = 19'd359997;
    #1;
    release dut_b.live_count;
    step(1);                     // P315
    chk("b_live_359998", 32'(live_b), 359998);
    step(1);                     // P316
    chk("b_live_359999", 32'(live_b), 359999);
    chk("b_tick316",     32'(tick_b), 1);
    step(1);                     // P317
    chk("b_wrap_live",    32'(live_b),    0);
    chk("b_wrap_running", 32'(running_b), 1);
    chk("b_wrap_tick",    32'(tick_b),    1);
    step(1);                     // P318
    chk("b_post_wrap_live", 32'(live_b),   1);
    chk("b_post_wrap_disp", 32'(disp_b),   0);
    chk("b_frozen",         32'(frozen_b), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
